cond_logic: RTL and testbench
=============================

// Module: cond_logic
// PURPOSE
//  Consumer of the ALU decoder's FlagW/ALUControl results in the ARMv4 core.
//  - Holds the NZCV status register.
//  - Evaluates the 4-bit instruction condition field against the stored flags.
//  - Gates the control unit's PCS/RegW/MemW strobes, so only condition-passing instructions change architectural state.
//  - Sits between the control unit (main + ALU decoder) and the datapath write enables.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset (bit3=N, bit2=Z, bit1=C, bit0=V)
//  REG_OUT      0        0: PCSrc/RegWrite/MemWrite combinational; 1: registered, +1 cycle latency
// PORTS
//  clk         in   1  rising-edge clock
//  reset_n     in   1  asynchronous, active-low reset
//  Valid       in   1  instruction in this cycle is real (0 = bubble)
//  Stall       in   1  hold flag register; outputs still evaluated
//  Cond        in   4  instruction condition field Instr[31:28]
//  ALUFlags    in   4  {N,Z,C,V} produced by the ALU this cycle
//  FlagW       in   2  from ALU decoder: [1] update N,Z; [0] update C,V
//  PCS         in   1  instruction writes PC (branch or Rd=R15)
//  RegW        in   1  instruction writes register file
//  MemW        in   1  instruction writes memory
//  NoWrite     in   1  compare-type op: suppress RegWrite
//  PCSrc       out  1  gated PCS
//  RegWrite    out  1  gated RegW
//  MemWrite    out  1  gated MemW
//  CondEx      out  1  condition passed (always combinational)
//  Flags       out  4  current NZCV register contents
// BEHAVIOUR
//  Reset (reset_n=0, async): Flags=RESET_FLAGS; registered outputs (REG_OUT=1) clear to 0.
//   All updates are blocked while reset_n=0. Deassertion takes effect at the next clk edge.
//  CondEx is computed from Cond and the stored Flags, never from ALUFlags:
//   0000 EQ  Z              0001 NE  ~Z
//   0010 CS  C              0011 CC  ~C
//   0100 MI  N              0101 PL  ~N
//   0110 VS  V              0111 VC  ~V
//   1000 HI  C&~Z           1001 LS  ~C|Z
//   1010 GE  N==V           1011 LT  N!=V
//   1100 GT  ~Z&(N==V)      1101 LE  Z|(N!=V)
//   1110 AL  1              1111 reserved -> 0 (never executes)
//  Gating:
//   PCSrc    = Valid & CondEx & PCS
//   RegWrite = Valid & CondEx & RegW & ~NoWrite
//   MemWrite = Valid & CondEx & MemW
//  REG_OUT=1: the three gated strobes are sampled at the clk edge and appear one cycle later.
//   CondEx and Flags are unaffected by REG_OUT.
//  Flag update: at a rising clk edge with Valid & CondEx & ~Stall:
//   - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
//   - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
//   - The two halves update independently. FlagW=2'b10 (logical ops) leaves C,V untouched.
//   - The new flags are visible to CondEx in the cycle after the edge.
//  Failed condition, Valid=0 or Stall=1: Flags hold. A failing instruction never updates flags.
//  Reset asserted mid-instruction: pending update is discarded; Flags=RESET_FLAGS immediately.
//  Unknown/X on Cond while Valid=0 must not corrupt Flags.
// TESTING
//  1. Reset with RESET_FLAGS=0 -> Flags=0000. Cond=0000 (EQ) -> CondEx=0. Cond=1110 (AL) -> CondEx=1.
//  2. Cond=1110, FlagW=11, ALUFlags=0110, Valid=1 -> next cycle Flags=0110, Cond=0000 (EQ) CondEx=1.
//  3. Flags=0110; FlagW=10, ALUFlags=1001 -> Flags=1010 (C kept 1, V kept 0).
//  4. Flags=0100 (Z=1); Cond=0001 (NE), RegW=1, MemW=1, FlagW=11, ALUFlags=1111 ->
//     RegWrite=0, MemWrite=0, Flags stays 0100.
//  5. Flags=1000 (N=1,V=0): Cond=1011 LT -> CondEx=1, Cond=1100 GT -> 0;
//     Cond=1111 -> CondEx=0. Stall=1 with FlagW=11 -> Flags unchanged.
//  6. REG_OUT=1: PCS=1, Cond=1110, Valid=1 at edge k -> PCSrc=1 during cycle k+1 only.
//     reset_n pulled low mid-cycle -> PCSrc=0 and Flags=RESET_FLAGS without waiting for clk.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution unit for the ARMv4 core.
// Holds the NZCV status register and checks the instruction condition field
// against the stored flags. The PC, register-file and memory write strobes
// from the control unit are gated, so an instruction that fails its
// condition does not change architectural state.
module cond_logic #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         REG_OUT     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Valid,
  input  logic       Stall,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags_q;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;
  logic       flag_en;
  logic       pcsrc_d, regwrite_d, memwrite_d;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluate the condition field against the stored flags only. ALUFlags is
  // deliberately excluded, so the result an instruction produces cannot
  // decide whether that same instruction executes.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign CondEx = cond_ex;
  assign Flags  = flags_q;

  // Valid is the first term, so an unknown Cond during a bubble evaluates to
  // a disabled update and cannot corrupt the flags.
  assign flag_en = Valid & cond_ex & ~Stall;

  // NZ and CV are written independently. Logical ops set only FlagW[1], so
  // the carry and overflow flags are preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= RESET_FLAGS;
    end else if (flag_en) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcsrc_d    = Valid & cond_ex & PCS;
  assign regwrite_d = Valid & cond_ex & RegW & ~NoWrite;
  assign memwrite_d = Valid & cond_ex & MemW;

  generate
    if (REG_OUT) begin : g_reg_out
      logic pcsrc_q, regwrite_q, memwrite_q;

      // Registered strobes: one cycle of latency, cleared immediately on reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pcsrc_q    <= 1'b0;
          regwrite_q <= 1'b0;
          memwrite_q <= 1'b0;
        end else begin
          pcsrc_q    <= pcsrc_d;
          regwrite_q <= regwrite_d;
          memwrite_q <= memwrite_d;
        end
      end

      assign PCSrc    = pcsrc_q;
      assign RegWrite = regwrite_q;
      assign MemWrite = memwrite_q;
    end else begin : g_comb_out
      assign PCSrc    = pcsrc_d;
      assign RegWrite = regwrite_d;
      assign MemWrite = memwrite_d;
    end
  endgenerate

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic. Two instances share the same stimulus:
// one with combinational strobes and default reset flags, and one with
// registered strobes and non-zero reset flags.
module tb_cond_logic;

  logic       clk;
  logic       reset_n;
  logic       Valid, Stall;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;

  logic       c_pcsrc, c_regwrite, c_memwrite, c_condex;
  logic [3:0] c_flags;
  logic       r_pcsrc, r_regwrite, r_memwrite, r_condex;
  logic [3:0] r_flags;

  int checks   = 0;
  int failures = 0;

  cond_logic #(.RESET_FLAGS(4'b0000), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .reset_n(reset_n), .Valid(Valid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .PCSrc(c_pcsrc), .RegWrite(c_regwrite),
    .MemWrite(c_memwrite), .CondEx(c_condex), .Flags(c_flags)
  );

  cond_logic #(.RESET_FLAGS(4'b1010), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .reset_n(reset_n), .Valid(Valid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .PCSrc(r_pcsrc), .RegWrite(r_regwrite),
    .MemWrite(r_memwrite), .CondEx(r_condex), .Flags(r_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Valid = 0; Stall = 0; FlagW = 2'b00; ALUFlags = 4'b0000;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Cond = 4'b1110;
  endtask

  // Load the flags through an AL instruction that updates all four flags.
  task automatic load_flags(input logic [3:0] f);
    idle();
    Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    idle();
    #1;
  endtask

  // Expected CondEx for conditions 0000..1111 with Flags=0110 and Flags=1000.
  logic exp_0110 [16] = '{1,0,1,0,0,1,0,1,0,1,1,0,0,1,1,0};
  logic exp_1000 [16] = '{0,1,0,1,1,0,0,1,0,1,0,1,0,1,1,0};

  initial begin
    idle();
    Cond = 4'b0000;
    reset_n = 0;
    tick(); tick();
    chk("rst_flags_comb", c_flags, 4'b0000);
    chk("rst_flags_reg",  r_flags, 4'b1010);
    chk("rst_pcsrc_reg",  {3'b0, r_pcsrc}, 4'b0);
    reset_n = 1;
    tick();

    // Test 1: CondEx with the reset flags.
    Cond = 4'b0000; #1;
    chk("eq_after_rst", {3'b0, c_condex}, 4'b0);
    Cond = 4'b1110; #1;
    chk("al_after_rst", {3'b0, c_condex}, 4'b1);

    // Test 2: full flag update; the new flags become visible after the edge.
    Valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110; #1;
    chk("flags_before_edge", c_flags, 4'b0000);
    tick();
    idle();
    Cond = 4'b0000; #1;
    chk("flags_upd_0110", c_flags, 4'b0110);
    chk("flags_upd_0110_reg", r_flags, 4'b0110);
    chk("eq_z1", {3'b0, c_condex}, 4'b1);
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i); #1;
      chk($sformatf("cond_0110_%0d", i), {3'b0, c_condex}, {3'b0, exp_0110[i]});
    end

    // Gating with EQ passing.
    Valid = 1; Cond = 4'b0000; RegW = 1; MemW = 1; PCS = 1; NoWrite = 0; #1;
    chk("gate_pass", {1'b0, c_pcsrc, c_regwrite, c_memwrite}, 4'b0111);
    NoWrite = 1; #1;
    chk("gate_nowrite", {1'b0, c_pcsrc, c_regwrite, c_memwrite}, 4'b0101);
    Valid = 0; #1;
    chk("gate_bubble", {1'b0, c_pcsrc, c_regwrite, c_memwrite}, 4'b0000);
    idle();

    // Test 3: NZ-only update keeps C and V.
    Valid = 1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1001;
    tick(); idle(); #1;
    chk("flagw_10", c_flags, 4'b1010);
    // CV-only update keeps N and Z.
    Valid = 1; Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b0101;
    tick(); idle(); #1;
    chk("flagw_01", c_flags, 4'b1001);

    // Test 4: NE fails with Z=1; the strobes and the flag update are blocked.
    load_flags(4'b0100);
    chk("load_0100", c_flags, 4'b0100);
    Valid = 1; Cond = 4'b0001; RegW = 1; MemW = 1; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    chk("ne_condex", {3'b0, c_condex}, 4'b0);
    chk("ne_gated", {1'b0, c_pcsrc, c_regwrite, c_memwrite}, 4'b0000);
    tick(); idle(); #1;
    chk("ne_flags_hold", c_flags, 4'b0100);
    chk("ne_reg_strobes", {1'b0, r_pcsrc, r_regwrite, r_memwrite}, 4'b0000);

    // Test 5: N=1, V=0.
    load_flags(4'b1000);
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i); #1;
      chk($sformatf("cond_1000_%0d", i), {3'b0, c_condex}, {3'b0, exp_1000[i]});
    end
    Valid = 1; Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b0111;
    tick(); idle(); #1;
    chk("reserved_no_upd", c_flags, 4'b1000);
    Valid = 1; Stall = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0001; #1;
    chk("stall_condex", {3'b0, c_condex}, 4'b1);
    tick(); idle(); #1;
    chk("stall_hold", c_flags, 4'b1000);
    Valid = 0; Cond = 4'bxxxx; FlagW = 2'b11; ALUFlags = 4'b0101;
    tick(); idle(); #1;
    chk("bubble_x_cond", c_flags, 4'b1000);

    // Test 6: the registered strobe is delayed by one cycle and lasts one cycle.
    Valid = 1; Cond = 4'b1110; PCS = 1; #1;
    chk("comb_pcsrc_now", {3'b0, c_pcsrc}, 4'b1);
    chk("reg_pcsrc_before", {3'b0, r_pcsrc}, 4'b0);
    tick();
    idle(); #1;
    chk("reg_pcsrc_k1", {3'b0, r_pcsrc}, 4'b1);
    tick();
    chk("reg_pcsrc_k2", {3'b0, r_pcsrc}, 4'b0);
    Valid = 1; Cond = 4'b1110; RegW = 1; MemW = 1;
    tick(); #1;
    chk("reg_rw_mw", {1'b0, r_pcsrc, r_regwrite, r_memwrite}, 4'b0011);
    // Asynchronous reset mid-cycle, with an update pending.
    idle();
    Valid = 1; Cond = 4'b1110; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b0011;
    tick();
    chk("reg_pcsrc_pre_rst", {3'b0, r_pcsrc}, 4'b1);
    #2 reset_n = 0;
    #1;
    chk("async_pcsrc", {3'b0, r_pcsrc}, 4'b0);
    chk("async_flags_reg", r_flags, 4'b1010);
    chk("async_flags_comb", c_flags, 4'b0000);
    tick();
    chk("rst_hold_flags", c_flags, 4'b0000);
    chk("rst_hold_strobes", {1'b0, r_pcsrc, r_regwrite, r_memwrite}, 4'b0000);
    reset_n = 1;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
